// File: rtl/video_sync_generator.sv
// SD hsync/vsync/field timing generator (576i50, 480i60, 576p50, 480p60) from a 50 MHz clock.
// Optional composite sync on csync_out when VIDEO_SYNC_CSYNC_EN is defined.
module video_sync_generator #(
    parameter int unsigned LINE_CLKS_I50 = 3200,
    parameter int unsigned LINE_CLKS_I60 = 3178,
    parameter int unsigned HSYNC_CLKS_I  = 235,
    parameter int unsigned HSYNC_CLKS_P  = 118
) (
    input  logic       clk_50mhz_in,
    input  logic       reset_in,
    input  logic [7:0] video_format,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       field_out,
    output logic       frame_start_out,
    output logic [9:0] line_out,
    output logic       csync_out
);
    localparam int unsigned HW = 12;
    localparam int unsigned LW = 10;

    localparam logic [2:0] FMT_OFF  = 3'd0;
    localparam logic [2:0] FMT_576I = 3'd1;
    localparam logic [2:0] FMT_480I = 3'd2;
    localparam logic [2:0] FMT_576P = 3'd3;
    localparam logic [2:0] FMT_480P = 3'd4;

    logic [2:0]    r_fmt;
    logic [HW-1:0] r_h_cnt;
    logic [LW-1:0] r_line;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_field;
    logic          r_frame_start;

    logic [2:0]    w_fmt_in;
    logic [2:0]    w_fmt_nxt;
    logic [HW-1:0] w_h_nxt;
    logic [LW-1:0] w_line_nxt;
    logic          w_h_last;
    logic          w_l_last;
    logic [HW-1:0] w_len;
    logic [HW-1:0] w_half;
    logic          w_at_half;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_field;
    logic          w_fs;

    function automatic logic [2:0] fmt_of(input logic [7:0] code);
        logic [2:0] f;
        case (code)
            8'h01:   f = FMT_576I;
            8'h02:   f = FMT_480I;
            8'h03:   f = FMT_576P;
            8'h04:   f = FMT_480P;
            default: f = FMT_OFF;
        endcase
        return f;
    endfunction

    function automatic logic [HW-1:0] len_of(input logic [2:0] f);
        logic [HW-1:0] l;
        case (f)
            FMT_576I: l = HW'(LINE_CLKS_I50);
            FMT_480I: l = HW'(LINE_CLKS_I60);
            FMT_576P: l = HW'(LINE_CLKS_I50 / 2);
            FMT_480P: l = HW'(LINE_CLKS_I60 / 2);
            default:  l = HW'(1);
        endcase
        return l;
    endfunction

    function automatic logic [LW-1:0] lines_of(input logic [2:0] f);
        logic [LW-1:0] n;
        case (f)
            FMT_576I, FMT_576P: n = LW'(625);
            FMT_480I, FMT_480P: n = LW'(525);
            default:            n = LW'(1);
        endcase
        return n;
    endfunction

    // Next-state: format reloads only while off or at frame wrap, which also restarts the counters
    always_comb begin
        w_fmt_in   = fmt_of(video_format);
        w_fmt_nxt  = r_fmt;
        w_h_nxt    = r_h_cnt;
        w_line_nxt = r_line;
        w_h_last   = (r_h_cnt == len_of(r_fmt) - HW'(1));
        w_l_last   = (r_line == lines_of(r_fmt) - LW'(1));
        if ((r_fmt == FMT_OFF) || (w_h_last && w_l_last)) begin
            w_fmt_nxt  = w_fmt_in;
            w_h_nxt    = '0;
            w_line_nxt = '0;
        end else if (w_h_last) begin
            w_h_nxt    = '0;
            w_line_nxt = r_line + LW'(1);
        end else begin
            w_h_nxt    = r_h_cnt + HW'(1);
        end
    end

    // Output decode from next-state counters so every output lands with its counter value
    always_comb begin
        w_hs_n    = 1'b1;
        w_vs_n    = 1'b1;
        w_field   = 1'b0;
        w_fs      = 1'b0;
        w_len     = len_of(w_fmt_nxt);
        w_half    = w_len >> 1;
        w_at_half = (w_h_nxt >= w_half);
        case (w_fmt_nxt)
            FMT_576I: begin
                w_hs_n  = (w_h_nxt >= HW'(HSYNC_CLKS_I));
                w_vs_n  = !((w_line_nxt < LW'(2)) || ((w_line_nxt == LW'(2)) && !w_at_half) ||
                            ((w_line_nxt == LW'(312)) && w_at_half) ||
                            (w_line_nxt == LW'(313)) || (w_line_nxt == LW'(314)));
                w_field = (w_line_nxt > LW'(312)) || ((w_line_nxt == LW'(312)) && w_at_half);
                w_fs    = ((w_line_nxt == LW'(0)) && (w_h_nxt == HW'(0))) ||
                          ((w_line_nxt == LW'(312)) && (w_h_nxt == w_half));
            end
            FMT_480I: begin
                w_hs_n  = (w_h_nxt >= HW'(HSYNC_CLKS_I));
                w_vs_n  = !((w_line_nxt < LW'(3)) ||
                            ((w_line_nxt == LW'(262)) && w_at_half) ||
                            (w_line_nxt == LW'(263)) || (w_line_nxt == LW'(264)) ||
                            ((w_line_nxt == LW'(265)) && !w_at_half));
                w_field = (w_line_nxt > LW'(262)) || ((w_line_nxt == LW'(262)) && w_at_half);
                w_fs    = ((w_line_nxt == LW'(0)) && (w_h_nxt == HW'(0))) ||
                          ((w_line_nxt == LW'(262)) && (w_h_nxt == w_half));
            end
            FMT_576P: begin
                w_hs_n  = (w_h_nxt >= HW'(HSYNC_CLKS_P));
                w_vs_n  = (w_line_nxt >= LW'(5));
                w_fs    = (w_line_nxt == LW'(0)) && (w_h_nxt == HW'(0));
            end
            FMT_480P: begin
                w_hs_n  = (w_h_nxt >= HW'(HSYNC_CLKS_P));
                w_vs_n  = (w_line_nxt >= LW'(6));
                w_fs    = (w_line_nxt == LW'(0)) && (w_h_nxt == HW'(0));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
        if (reset_in) begin
            r_fmt         <= FMT_OFF;
            r_h_cnt       <= '0;
            r_line        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_field       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_fmt         <= w_fmt_nxt;
            r_h_cnt       <= w_h_nxt;
            r_line        <= w_line_nxt;
            r_hsync       <= w_hs_n;
            r_vsync       <= w_vs_n;
            r_field       <= w_field;
            r_frame_start <= w_fs;
        end
    end

    assign hsync_out       = r_hsync;
    assign vsync_out       = r_vsync;
    assign field_out       = r_field;
    assign frame_start_out = r_frame_start;
    assign line_out        = r_line;

`ifdef VIDEO_SYNC_CSYNC_EN
    logic r_csync;

    always_ff @(posedge clk_50mhz_in or posedge reset_in) begin
        if (reset_in) begin
            r_csync <= 1'b1;
        end else begin
            r_csync <= w_hs_n & w_vs_n;
        end
    end

    assign csync_out = r_csync;
`else
    assign csync_out = 1'b1;
`endif

endmodule

// File: tb/tb_video_sync_generator.sv
// Scoreboard bench for video_sync_generator with shortened line lengths; the reference model
// tracks the absolute clock position within the frame and derives every output from it.
module tb_video_sync_generator;
    localparam int L50 = 20;
    localparam int L60 = 18;
    localparam int HSI = 4;
    localparam int HSP = 2;

    typedef struct packed {
        logic [9:0] line;
        logic       hs;
        logic       vs;
        logic       fld;
        logic       fs;
        logic       cs;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] vf  = 8'h00;

    logic       hsync_out;
    logic       vsync_out;
    logic       field_out;
    logic       frame_start_out;
    logic [9:0] line_out;
    logic       csync_out;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    video_sync_generator #(
        .LINE_CLKS_I50(L50),
        .LINE_CLKS_I60(L60),
        .HSYNC_CLKS_I (HSI),
        .HSYNC_CLKS_P (HSP)
    ) dut (
        .clk_50mhz_in   (clk),
        .reset_in       (rst),
        .video_format   (vf),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .field_out      (field_out),
        .frame_start_out(frame_start_out),
        .line_out       (line_out),
        .csync_out      (csync_out)
    );

    always #10 clk = ~clk;

    function automatic int line_len(input logic [7:0] f);
        int l;
        l = (f == 8'h01 || f == 8'h03) ? L50 : L60;
        if (f == 8'h03 || f == 8'h04) l = l / 2;
        return l;
    endfunction

    function automatic int frame_len(input logic [7:0] f);
        return line_len(f) * ((f == 8'h01 || f == 8'h03) ? 625 : 525);
    endfunction

    // Expected outputs for format f at clock position p of the frame
    function automatic obs_t model_out(input logic [7:0] f, input int p);
        obs_t e;
        int   l;
        int   half;
        logic vlow;
        e = '{line: 10'd0, hs: 1'b1, vs: 1'b1, fld: 1'b0, fs: 1'b0, cs: 1'b1};
        if (f >= 8'h01 && f <= 8'h04) begin
            l      = line_len(f);
            half   = frame_len(f) / 2;
            e.line = 10'(p / l);
            if (f <= 8'h02) begin
                e.hs = !((p % l) < HSI);
                if (f == 8'h01) vlow = (2 * p < 5 * l) || (p >= half && p < 315 * l);
                else            vlow = (p < 3 * l) || (p >= half && 2 * p < 531 * l);
                e.fld = (p >= half);
                e.fs  = (p == 0) || (p == half);
            end else begin
                e.hs  = !((p % l) < HSP);
                vlow  = p < ((f == 8'h03) ? 5 : 6) * l;
                e.fs  = (p == 0);
            end
            e.vs = !vlow;
`ifdef VIDEO_SYNC_CSYNC_EN
            e.cs = e.hs & e.vs;
`endif
        end
        return e;
    endfunction

    // Reference model: produces the expected post-edge outputs
    initial begin : model
        logic [7:0] m_fmt;
        int         m_p;
        m_fmt = 8'h00;
        m_p   = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_fmt = 8'h00;
                m_p   = 0;
                q.delete();
                q.push_back(model_out(8'h00, 0));
            end else begin
                if (m_fmt == 8'h00 || m_p == frame_len(m_fmt) - 1) begin
                    m_fmt = (vf >= 8'h01 && vf <= 8'h04) ? vf : 8'h00;
                    m_p   = 0;
                end else begin
                    m_p = m_p + 1;
                end
                q.push_back(model_out(m_fmt, m_p));
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard on the falling edge
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{line: line_out, hs: hsync_out, vs: vsync_out, fld: field_out,
                      fs: frame_start_out, cs: csync_out};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL sync_outputs t=%0t got line=%0d hs=%b vs=%b fld=%b fs=%b cs=%b exp line=%0d hs=%b vs=%b fld=%b fs=%b cs=%b",
                             $time, a.line, a.hs, a.vs, a.fld, a.fs, a.cs,
                             e.line, e.hs, e.vs, e.fld, e.fs, e.cs);
                    if (errors >= 200) begin
                        $display("Result: errors=%0d of %0d checks", errors, checks);
                        $finish;
                    end
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] f);
        @(posedge clk);
        #2 rst = 1'b1;
        vf = f;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] codes [6];
        codes[0] = 8'h01; codes[1] = 8'h02; codes[2] = 8'h03;
        codes[3] = 8'h04; codes[4] = 8'h00; codes[5] = 8'h7F;

        vf = 8'h01;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Full 576i frame, then into the next frame up to line 300 and reset there
        run(frame_len(8'h01) + 300 * L50 + 5);
        do_reset(8'h7F);
        run(50);
        vf = 8'h02;
        run(300);
        // 480p, switch to 576p mid-frame, then to 480i at line 100 of 576p
        do_reset(8'h04);
        run(2000);
        vf = 8'h03;
        run(frame_len(8'h04) - 2000 + 100 * (L50 / 2));
        vf = 8'h02;
        run(frame_len(8'h03) - 100 * (L50 / 2) + 500);
        // Randomized format changes and occasional resets
        for (int s = 0; s < 8; s++) begin
            int   pick;
            logic [7:0] code;
            pick = int'($urandom_range(0, 6));
            code = (pick == 6) ? 8'($urandom) : codes[pick];
            if ($urandom_range(0, 3) == 0) do_reset(code);
            else vf = code;
            run(int'($urandom_range(20, 6000)));
        end
        run(5);
        checks++;
        if (checks < 25000) begin
            errors++;
            $display("FAIL check_count got=%0d need>=25000", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
